// File: rtl/reg_file.sv
// +-----------------------------------------------------------------------------
// | Module      : reg_file
// | Description : Architectural register file with per-register rename tags.
// |               Optional macro REGFILE_COMMIT_BYPASS_EN forwards a matching
// |               same-cycle commit onto the query ports.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module reg_file #(
   parameter int REG_NUM   = 32,
   parameter int REG_POS_W = 5,
   parameter int DATA_W    = 32,
   parameter int ROB_POS_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue,
   input  logic [REG_POS_W-1:0] issue_rd,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   input  logic                 reg_write,
   input  logic [REG_POS_W-1:0] reg_rd,
   input  logic [DATA_W-1:0]    reg_val,
   input  logic [ROB_POS_W-1:0] commit_rob_pos,
   input  logic [REG_POS_W-1:0] rs1_pos,
   output logic [DATA_W-1:0]    rs1_val,
   output logic                 rs1_busy,
   output logic [ROB_POS_W-1:0] rs1_rob_pos,
   input  logic [REG_POS_W-1:0] rs2_pos,
   output logic [DATA_W-1:0]    rs2_val,
   output logic                 rs2_busy,
   output logic [ROB_POS_W-1:0] rs2_rob_pos
);

   logic [DATA_W-1:0]    val_q [REG_NUM];
   logic [DATA_W-1:0]    val_d [REG_NUM];
   logic [ROB_POS_W-1:0] tag_q [REG_NUM];
   logic [ROB_POS_W-1:0] tag_d [REG_NUM];
   logic [REG_NUM-1:0]   busy_q;
   logic [REG_NUM-1:0]   busy_d;

   logic commit_en;
   logic commit_hit;
   logic issue_en;

   // x0 is reset to zero and never selected for update, so it reads as zero.
   assign commit_en  = reg_write && (reg_rd != '0);
   assign commit_hit = commit_en && busy_q[reg_rd] && (tag_q[reg_rd] == commit_rob_pos);
   assign issue_en   = issue && (issue_rd != '0) && !rollback;

   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (commit_en) begin
         val_d[reg_rd] = reg_val;
      end
      if (commit_hit) begin
         busy_d[reg_rd] = 1'b0;
      end
      if (rollback) begin
         busy_d = '0;
         tag_d  = '{default: '0};
      end else if (issue_en) begin
         busy_d[issue_rd] = 1'b1;
         tag_d[issue_rd]  = issue_rob_pos;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q  <= '{default: '0};
         tag_q  <= '{default: '0};
         busy_q <= '0;
      end else if (rdy) begin
         val_q  <= val_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rs1_val     = val_q[rs1_pos];
      rs1_busy    = busy_q[rs1_pos];
      rs1_rob_pos = tag_q[rs1_pos];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (commit_hit && (rs1_pos == reg_rd)) begin
         rs1_val     = reg_val;
         rs1_busy    = 1'b0;
         rs1_rob_pos = '0;
      end
`else
`endif
   end

   always_comb begin
      rs2_val     = val_q[rs2_pos];
      rs2_busy    = busy_q[rs2_pos];
      rs2_rob_pos = tag_q[rs2_pos];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (commit_hit && (rs2_pos == reg_rd)) begin
         rs2_val     = reg_val;
         rs2_busy    = 1'b0;
         rs2_rob_pos = '0;
      end
`else
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_reg_file
// | Description : Self-checking bench for reg_file: directed cases plus random
// |               traffic compared every cycle against an array-based model.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_rob_pos;
   logic        reg_write;
   logic [4:0]  reg_rd;
   logic [31:0] reg_val;
   logic [3:0]  commit_rob_pos;
   logic [4:0]  rs1_pos;
   logic [31:0] rs1_val;
   logic        rs1_busy;
   logic [3:0]  rs1_rob_pos;
   logic [4:0]  rs2_pos;
   logic [31:0] rs2_val;
   logic        rs2_busy;
   logic [3:0]  rs2_rob_pos;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   bit [31:0] m_val  [32];
   bit        m_busy [32];
   bit [3:0]  m_tag  [32];

   reg_file #(
      .REG_NUM   (32),
      .REG_POS_W (5),
      .DATA_W    (32),
      .ROB_POS_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rollback       (rollback),
      .issue          (issue),
      .issue_rd       (issue_rd),
      .issue_rob_pos  (issue_rob_pos),
      .reg_write      (reg_write),
      .reg_rd         (reg_rd),
      .reg_val        (reg_val),
      .commit_rob_pos (commit_rob_pos),
      .rs1_pos        (rs1_pos),
      .rs1_val        (rs1_val),
      .rs1_busy       (rs1_busy),
      .rs1_rob_pos    (rs1_rob_pos),
      .rs2_pos        (rs2_pos),
      .rs2_val        (rs2_val),
      .rs2_busy       (rs2_busy),
      .rs2_rob_pos    (rs2_rob_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: plain per-register arrays updated by the commit/issue/rollback rules.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
         end
      end else if (rdy) begin
         if (reg_write && reg_rd != 0) begin
            m_val[reg_rd] = reg_val;
            if (m_busy[reg_rd] && m_tag[reg_rd] == commit_rob_pos) m_busy[reg_rd] = 1'b0;
         end
         if (rollback) begin
            for (int i = 0; i < 32; i++) begin
               m_busy[i] = 1'b0; m_tag[i] = '0;
            end
         end else if (issue && issue_rd != 0) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_rob_pos;
         end
      end
   end

   task automatic expect_port(input logic [4:0] pos, output logic [31:0] v,
                              output logic b, output logic [3:0] t);
      v = m_val[pos]; b = m_busy[pos]; t = m_tag[pos];
      if (pos == 0) begin
         v = '0; b = 1'b0; t = '0;
      end
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (reg_write && pos == reg_rd && pos != 0 && b && t == commit_rob_pos) begin
         v = reg_val; b = 1'b0; t = '0;
      end
`endif
   endtask

   always @(negedge clk) begin
      logic [31:0] ev;
      logic        eb;
      logic [3:0]  et;
      if (cmp_en) begin
         expect_port(rs1_pos, ev, eb, et);
         chk("rs1_val",  rs1_val, ev);
         chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, eb});
         chk("rs1_tag",  {28'd0, rs1_rob_pos}, {28'd0, et});
         expect_port(rs2_pos, ev, eb, et);
         chk("rs2_val",  rs2_val, ev);
         chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, eb});
         chk("rs2_tag",  {28'd0, rs2_rob_pos}, {28'd0, et});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue = 1'b0; reg_write = 1'b0; rollback = 1'b0; rdy = 1'b1;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
      issue = 1'b1; issue_rd = rd; issue_rob_pos = tag;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] pos);
      reg_write = 1'b1; reg_rd = rd; reg_val = v; commit_rob_pos = pos;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; issue_rd = '0;
      issue_rob_pos = '0; reg_write = 1'b0; reg_rd = '0; reg_val = '0;
      commit_rob_pos = '0; rs1_pos = '0; rs2_pos = '0;
      cyc(); cyc();
      rst = 1'b0;
      rs1_pos = 5;
      #1;
      chk("reset_val", rs1_val, 32'h0);
      chk("reset_busy", {31'd0, rs1_busy}, 32'h0);
      chk("reset_tag", {28'd0, rs1_rob_pos}, 32'h0);
      cmp_en = 1'b1;

      do_issue(5, 3); cyc();
      idle(); do_commit(5, 32'hDEADBEEF, 3); cyc();
      idle(); #1;
      chk("x5_val", rs1_val, 32'hDEADBEEF);
      chk("x5_busy", {31'd0, rs1_busy}, 32'h0);

      do_issue(7, 2); cyc();
      do_issue(7, 6); cyc();
      idle(); do_commit(7, 32'h11, 2); cyc();
      idle(); rs1_pos = 7; #1;
      chk("x7_old_val", rs1_val, 32'h11);
      chk("x7_old_busy", {31'd0, rs1_busy}, 32'h1);
      chk("x7_old_tag", {28'd0, rs1_rob_pos}, 32'h6);
      do_commit(7, 32'h22, 6); cyc();
      idle(); #1;
      chk("x7_val", rs1_val, 32'h22);
      chk("x7_busy", {31'd0, rs1_busy}, 32'h0);

      do_issue(0, 1); do_commit(0, 32'hFF, 1); cyc();
      idle(); rs2_pos = 0; #1;
      chk("x0_val", rs2_val, 32'h0);
      chk("x0_busy", {31'd0, rs2_busy}, 32'h0);
      chk("x0_tag", {28'd0, rs2_rob_pos}, 32'h0);

      do_issue(3, 4); cyc();
      do_issue(9, 5); cyc();
      idle(); rollback = 1'b1; do_commit(9, 32'h42, 5); do_issue(10, 7); cyc();
      idle(); rs1_pos = 3; rs2_pos = 9; #1;
      chk("rb_x3_busy", {31'd0, rs1_busy}, 32'h0);
      chk("rb_x9_val", rs2_val, 32'h42);
      chk("rb_x9_busy", {31'd0, rs2_busy}, 32'h0);
      rs1_pos = 10; #1;
      chk("rb_x10_busy", {31'd0, rs1_busy}, 32'h0);

      do_issue(4, 1); cyc();
      idle(); do_commit(4, 32'h99, 1); rs1_pos = 4; #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
      chk("byp_val", rs1_val, 32'h99);
      chk("byp_busy", {31'd0, rs1_busy}, 32'h0);
      chk("byp_tag", {28'd0, rs1_rob_pos}, 32'h0);
`else
      chk("nobyp_busy", {31'd0, rs1_busy}, 32'h1);
      chk("nobyp_tag", {28'd0, rs1_rob_pos}, 32'h1);
`endif
      cyc();
      idle(); #1;
      chk("x4_val", rs1_val, 32'h99);
      chk("x4_busy", {31'd0, rs1_busy}, 32'h0);

      rdy = 1'b0; do_issue(12, 9); do_commit(5, 32'h1234, 0); cyc();
      cyc();
      rs1_pos = 12; rs2_pos = 5; #1;
      chk("frz_x12_busy", {31'd0, rs1_busy}, 32'h0);
      chk("frz_x5_val", rs2_val, 32'hDEADBEEF);
      idle();

      for (int n = 0; n < 3000; n++) begin
         cyc();
         rst       = ($urandom_range(0, 199) == 0);
         rdy       = ($urandom_range(0, 9) != 0);
         rollback  = ($urandom_range(0, 19) == 0);
         issue     = $urandom_range(0, 1) == 1;
         issue_rd  = 5'($urandom_range(0, 7));
         issue_rob_pos = 4'($urandom);
         reg_write = $urandom_range(0, 1) == 1;
         reg_rd    = 5'($urandom_range(0, 7));
         reg_val   = $urandom;
         commit_rob_pos = ($urandom_range(0, 1) == 1) ? m_tag[reg_rd] : 4'($urandom);
         rs1_pos   = ($urandom_range(0, 1) == 1) ? reg_rd : 5'($urandom_range(0, 9));
         rs2_pos   = 5'($urandom);
      end
      cyc();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
